ram_sdp_port_arbiter: RTL and testbench

Round-robin arbiter that shares one 512x32 simple-dual-port RAM (registered read, one write port, one read port) between N clients on a single clock.
- Write port and read port are arbitrated independently. One client can write while another reads in the same cycle.
- The block drives the RAM address, data and write-enable. It routes the registered read data back to the client that issued the read, with a per-client valid strobe.
- Sits between the DMA/host clients and the RAM instance. The RAM's read and write clocks are both tied to this block's clock.

---
 rtl/ram_sdp_port_arbiter_pkg.sv | 16 +
 rtl/ram_sdp_port_arbiter_if.sv | 33 +++
 rtl/ram_sdp_port_arbiter_rr.sv | 54 +++++
 rtl/ram_sdp_port_arbiter.sv | 74 +++++++
 tb/tb_ram_sdp_port_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_sdp_port_arbiter_pkg.sv
// Shared widths and helpers for the SDP RAM port arbiter.
// Exports ADDR_WIDTH, DATA_WIDTH, DEPTH and clog2().
package ram_arb_pkg;

   localparam int ADDR_WIDTH = 9;
   localparam int DATA_WIDTH = 32;
   localparam int DEPTH      = 512;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/ram_sdp_port_arbiter_if.sv
// Client-side bundle for the SDP RAM port arbiter.
// master: client (drives valid/addr/data); slave: arbiter.
interface ram_sdp_port_arbiter_if #(
   parameter int N_CLIENTS  = 2,
   parameter int DATA_WIDTH = ram_arb_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = ram_arb_pkg::ADDR_WIDTH
);

   logic [N_CLIENTS-1:0]            wr_valid;
   logic [N_CLIENTS-1:0]            wr_ready;
   logic [N_CLIENTS*ADDR_WIDTH-1:0] wr_addr;
   logic [N_CLIENTS*DATA_WIDTH-1:0] wr_data;
   logic [N_CLIENTS-1:0]            rd_valid;
   logic [N_CLIENTS-1:0]            rd_ready;
   logic [N_CLIENTS*ADDR_WIDTH-1:0] rd_addr;
   logic [N_CLIENTS-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]           rsp_data;

   modport master (
      output wr_valid, wr_addr, wr_data,
      output rd_valid, rd_addr,
      input  wr_ready, rd_ready,
      input  rsp_valid, rsp_data
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data,
      input  rd_valid, rd_addr,
      output wr_ready, rd_ready,
      output rsp_valid, rsp_data
   );

endinterface

// File: rtl/ram_sdp_port_arbiter_rr.sv
// Round-robin arbiter: one-hot grant from req, search
// starts at an internal pointer that moves past the winner.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   import ram_arb_pkg::*;

   localparam int IW = (clog2(N) < 1) ? 1 : clog2(N);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic [IW-1:0] idx;
   logic          found;
   int            s;
   int            nxt;

   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = '0;
      s     = 0;
      nxt   = 0;
      for (int k = 0; k < N; k++) begin
         s = int'(ptr_q) + k;
         if (s >= N) s = s - N;
         idx = IW'(s);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            nxt        = s + 1;
            if (nxt >= N) nxt = 0;
            ptr_d      = IW'(nxt);
         end
      end
      // Nothing is accepted while reset is held.
      if (!reset_n) begin
         grant = '0;
         ptr_d = ptr_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end

endmodule

// File: rtl/ram_sdp_port_arbiter.sv
// Shares one SDP RAM (registered read) between N clients.
// Ports: clock, reset_n, cl (client bundle), ram_* to RAM.
module ram_sdp_port_arbiter #(
   parameter int N_CLIENTS  = 2,
   parameter int DATA_WIDTH = ram_arb_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = ram_arb_pkg::ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset_n,
   ram_sdp_port_arbiter_if.slave cl,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_write_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   localparam int N  = N_CLIENTS;
   localparam int AW = ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;

   if (N < 2 || N > 4) begin : g_bad_n
      $error("N_CLIENTS must be in 2..4");
   end

   logic [N-1:0] wr_gnt;
   logic [N-1:0] rd_gnt;
   logic [N-1:0] rsp_tag;

   rr_arbiter #(.N(N)) u_wr_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (cl.wr_valid),
      .grant   (wr_gnt)
   );

   rr_arbiter #(.N(N)) u_rd_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (cl.rd_valid),
      .grant   (rd_gnt)
   );

   assign cl.wr_ready = wr_gnt;
   assign cl.rd_ready = rd_gnt;
   assign ram_we      = |wr_gnt;

   // Idle ports fall back to client 0 so nothing floats.
   always_comb begin
      ram_write_addr = cl.wr_addr[AW-1:0];
      ram_din        = cl.wr_data[DW-1:0];
      ram_read_addr  = cl.rd_addr[AW-1:0];
      for (int i = 0; i < N; i++) begin
         if (wr_gnt[i]) begin
            ram_write_addr = cl.wr_addr[i*AW +: AW];
            ram_din        = cl.wr_data[i*DW +: DW];
         end
         if (rd_gnt[i]) begin
            ram_read_addr = cl.rd_addr[i*AW +: AW];
         end
      end
   end

   // RAM registers the read; the tag follows it by one edge.
   always_ff @(posedge clock) begin
      if (!reset_n) rsp_tag <= '0;
      else          rsp_tag <= rd_gnt;
   end

   // A read in flight when reset asserts is dropped.
   assign cl.rsp_valid = rsp_tag & {N{reset_n}};
   assign cl.rsp_data  = ram_dout;

endmodule

// File: tb/tb_ram_sdp_port_arbiter.sv
// Directed bench for ram_sdp_port_arbiter, N_CLIENTS=2,
// with a behavioural read-before-write SDP RAM.
module tb_ram_sdp_port_arbiter;

   logic        clk;
   logic        reset_n;
   logic        ram_we;
   logic [8:0]  ram_write_addr;
   logic [31:0] ram_din;
   logic [8:0]  ram_read_addr;
   logic [31:0] ram_dout;
   logic [31:0] mem [512];

   int n_tests;
   int n_fail;

   typedef struct {
      logic [1:0]  wv;
      logic [1:0]  rv;
      logic [8:0]  wa0;
      logic [8:0]  wa1;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic [8:0]  ra0;
      logic [8:0]  ra1;
      logic [1:0]  ewr;
      logic [1:0]  erd;
      logic [1:0]  ersp;
      logic        chk;
      logic [31:0] edata;
   } vec_t;

   vec_t tv [19];

   ram_sdp_port_arbiter_if #(.N_CLIENTS(2)) cl ();

   ram_sdp_port_arbiter #(.N_CLIENTS(2)) dut (
      .clock          (clk),
      .reset_n        (reset_n),
      .cl             (cl),
      .ram_we         (ram_we),
      .ram_write_addr (ram_write_addr),
      .ram_din        (ram_din),
      .ram_read_addr  (ram_read_addr),
      .ram_dout       (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_write_addr] <= ram_din;
      ram_dout <= mem[ram_read_addr];
   end

   function automatic vec_t mk(
      input logic [1:0]  wv, input logic [1:0] rv,
      input logic [8:0]  wa0, input logic [31:0] wd0,
      input logic [8:0]  wa1, input logic [31:0] wd1,
      input logic [8:0]  ra0, input logic [8:0] ra1,
      input logic [1:0]  ewr, input logic [1:0] erd,
      input logic [1:0]  ersp,
      input logic        chk, input logic [31:0] edata);
      vec_t v;
      v.wv = wv;   v.rv = rv;
      v.wa0 = wa0; v.wd0 = wd0;
      v.wa1 = wa1; v.wd1 = wd1;
      v.ra0 = ra0; v.ra1 = ra1;
      v.ewr = ewr; v.erd = erd;
      v.ersp = ersp;
      v.chk = chk; v.edata = edata;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      cl.wr_valid = v.wv;
      cl.wr_addr  = {v.wa1, v.wa0};
      cl.wr_data  = {v.wd1, v.wd0};
      cl.rd_valid = v.rv;
      cl.rd_addr  = {v.ra1, v.ra0};
   endtask

   task automatic idle();
      cl.wr_valid = 2'b00;
      cl.rd_valid = 2'b00;
   endtask

   initial begin
      int w0, w1, r0, r1;
      logic [1:0] g;
      logic [1:0] prev;
      n_tests = 0;
      n_fail  = 0;
      w0 = 0; w1 = 0; r0 = 0; r1 = 0;

      // Directed rows; rsp columns refer to the prior row's read.
      tv[0] = mk(2'b11, 2'b11, 9'h1FF, 32'h12345678,
                 9'h010, 32'h0, 9'h000, 9'h000,
                 2'b01, 2'b01, 2'b00, 1'b0, 32'h0);
      tv[1] = mk(2'b11, 2'b11, 9'h1FF, 32'h12345678,
                 9'h010, 32'h0, 9'h000, 9'h000,
                 2'b10, 2'b10, 2'b01, 1'b0, 32'h0);
      tv[2] = mk(2'b10, 2'b00, 9'h000, 32'h0,
                 9'h1A5, 32'hDEADBEEF, 9'h000, 9'h000,
                 2'b10, 2'b00, 2'b10, 1'b0, 32'h0);
      tv[3] = mk(2'b00, 2'b10, 9'h000, 32'h0,
                 9'h000, 32'h0, 9'h000, 9'h1A5,
                 2'b00, 2'b10, 2'b00, 1'b0, 32'h0);
      tv[4] = mk(2'b00, 2'b00, 9'h000, 32'h0,
                 9'h000, 32'h0, 9'h000, 9'h000,
                 2'b00, 2'b00, 2'b10, 1'b1, 32'hDEADBEEF);
      tv[5] = mk(2'b01, 2'b10, 9'h000, 32'h0BADF00D,
                 9'h000, 32'h0, 9'h000, 9'h1FF,
                 2'b01, 2'b10, 2'b00, 1'b0, 32'h0);
      tv[6] = mk(2'b00, 2'b00, 9'h000, 32'h0,
                 9'h000, 32'h0, 9'h000, 9'h000,
                 2'b00, 2'b00, 2'b10, 1'b1, 32'h12345678);
      tv[7] = mk(2'b01, 2'b10, 9'h010, 32'hAAAA5555,
                 9'h000, 32'h0, 9'h000, 9'h010,
                 2'b01, 2'b10, 2'b00, 1'b0, 32'h0);
      tv[8] = mk(2'b00, 2'b01, 9'h000, 32'h0,
                 9'h000, 32'h0, 9'h010, 9'h000,
                 2'b00, 2'b01, 2'b10, 1'b1, 32'h0);
      tv[9] = mk(2'b00, 2'b00, 9'h000, 32'h0,
                 9'h000, 32'h0, 9'h000, 9'h000,
                 2'b00, 2'b00, 2'b01, 1'b1, 32'hAAAA5555);
      // Contention: both ports start with client 1 up.
      for (int k = 0; k < 8; k++) begin
         g    = (k % 2 == 0) ? 2'b10 : 2'b01;
         prev = (k == 0) ? 2'b00 :
                ((k % 2 == 1) ? 2'b10 : 2'b01);
         tv[10+k] = mk(2'b11, 2'b11,
                       9'h020, 32'h100 + k,
                       9'h021, 32'h200 + k,
                       9'h1A5, 9'h000, g, g, prev,
                       (k != 0),
                       (prev == 2'b10) ? 32'h0BADF00D
                                       : 32'hDEADBEEF);
      end
      tv[18] = mk(2'b00, 2'b00, 9'h000, 32'h0,
                  9'h000, 32'h0, 9'h000, 9'h000,
                  2'b00, 2'b00, 2'b01, 1'b1, 32'hDEADBEEF);

      // Reset held with every client requesting.
      reset_n = 1'b0;
      drive(tv[0]);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("rst_wr_ready", 32'(cl.wr_ready), 32'h0);
         chk("rst_rd_ready", 32'(cl.rd_ready), 32'h0);
         chk("rst_ram_we", 32'(ram_we), 32'h0);
         chk("rst_rsp_valid", 32'(cl.rsp_valid), 32'h0);
      end

      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 19; i++) begin
         if (i != 0) begin
            @(posedge clk); #1;
         end
         drive(tv[i]);
         @(negedge clk);
         chk($sformatf("v%0d_wr_ready", i),
             32'(cl.wr_ready), 32'(tv[i].ewr));
         chk($sformatf("v%0d_rd_ready", i),
             32'(cl.rd_ready), 32'(tv[i].erd));
         chk($sformatf("v%0d_ram_we", i),
             32'(ram_we), 32'(|tv[i].ewr));
         chk($sformatf("v%0d_rsp_valid", i),
             32'(cl.rsp_valid), 32'(tv[i].ersp));
         if (tv[i].chk)
            chk($sformatf("v%0d_rsp_data", i),
                cl.rsp_data, tv[i].edata);
         if (i >= 10 && i < 18) begin
            if (cl.wr_ready[0]) w0++;
            if (cl.wr_ready[1]) w1++;
            if (cl.rd_ready[0]) r0++;
            if (cl.rd_ready[1]) r1++;
         end
      end
      chk("fair_wr0", 32'(w0), 32'd4);
      chk("fair_wr1", 32'(w1), 32'd4);
      chk("fair_rd0", 32'(r0), 32'd4);
      chk("fair_rd1", 32'(r1), 32'd4);

      // Both pointers now sit at 1; read, then reset.
      @(posedge clk); #1;
      idle();
      cl.rd_valid = 2'b01;
      cl.rd_addr  = {9'h000, 9'h1A5};
      @(negedge clk);
      chk("mid_rd_ready", 32'(cl.rd_ready), 32'h1);

      @(posedge clk); #1;
      reset_n = 1'b0;
      idle();
      @(negedge clk);
      chk("mid_rsp_valid", 32'(cl.rsp_valid), 32'h0);

      @(posedge clk); #1;
      reset_n = 1'b1;
      cl.wr_valid = 2'b11;
      cl.rd_valid = 2'b11;
      @(negedge clk);
      chk("post_rsp_valid", 32'(cl.rsp_valid), 32'h0);
      chk("post_wr_ptr", 32'(cl.wr_ready), 32'h1);
      chk("post_rd_ptr", 32'(cl.rd_ready), 32'h1);

      @(posedge clk); #1;
      idle();
      @(negedge clk);
      chk("post_rsp_tag", 32'(cl.rsp_valid), 32'h1);
      chk("post_rsp_data", cl.rsp_data, 32'hDEADBEEF);

      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule
